lives_manager: RTL and testbench

- Parametrised player-lives controller; successor to the fixed 3-life debug counter.
- Accepts gameplay damage/pickup events and debug switches, all rising-edge detected.
- Enforces a frame-timed invulnerability window after each hit and drives game-over and blink signals to the player drawing and game-control logic.
- Sits between the collision logic, the switch inputs and the HUD/lives display.

---
 rtl/lives_pkg.sv | 16 +
 rtl/edge_detect.sv | 20 ++
 rtl/lives_manager.sv | 114 +++++++++++
 tb/tb_lives_manager.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/lives_pkg.sv
// Shared types and default parameter values for the player-lives controller.
package lives_pkg;

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    INVULN    = 2'd1,
    GAME_OVER = 2'd2
  } lives_state_e;

  localparam int DEF_MAX_LIVES     = 5;
  localparam int DEF_INIT_LIVES    = 3;
  localparam int DEF_LIVES_W       = 4;
  localparam int DEF_INVULN_FRAMES = 120;
  localparam int DEF_BLINK_BIT     = 3;

endpackage

// File: rtl/edge_detect.sv
// Multi-bit rising-edge detector: one-cycle pulse per 0->1 transition of each input bit.
module edge_detect #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev_p0;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) prev_p0 <= '0;
    else         prev_p0 <= din;
  end

  assign rise = din & ~prev_p0;

endmodule

// File: rtl/lives_manager.sv
// Player-lives controller: edge-detected damage/pickup/debug events, frame-timed
// invulnerability after gameplay hits, game-over latch and sprite blink.
module lives_manager
  import lives_pkg::*;
#(
  parameter int MAX_LIVES     = DEF_MAX_LIVES,
  parameter int INIT_LIVES    = DEF_INIT_LIVES,
  parameter int LIVES_W       = DEF_LIVES_W,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int BLINK_BIT     = DEF_BLINK_BIT
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               hit,
  input  logic               pickup,
  input  logic               sw_inc,
  input  logic               sw_dec,
  input  logic               restart,
  output logic [LIVES_W-1:0] lives,
  output logic               invulnerable,
  output logic               blink,
  output logic               life_lost,
  output logic               player_died,
  output logic               game_over
);

  // The counter must be wide enough both for the window length and for the blink tap.
  localparam int CNT_FR = $clog2(INVULN_FRAMES + 1);
  localparam int CNT_W  = (CNT_FR > BLINK_BIT + 1) ? CNT_FR : BLINK_BIT + 1;

  lives_state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [LIVES_W-1:0] lives_nxt;
  logic [3:0]       evt;
  logic             hit_evt, pickup_evt, inc_sw_evt, dec_sw_evt;
  logic             hit_acc, dec_evt, inc_evt, lost_nxt, died_nxt;

  function automatic logic [LIVES_W-1:0] sat_inc(input logic [LIVES_W-1:0] l);
    return (l >= LIVES_W'(MAX_LIVES)) ? LIVES_W'(MAX_LIVES) : l + 1'b1;
  endfunction

  function automatic logic [LIVES_W-1:0] sat_dec(input logic [LIVES_W-1:0] l);
    return (l == '0) ? '0 : l - 1'b1;
  endfunction

  edge_detect #(.WIDTH(4)) u_edge (
    .clk    (clk),
    .resetN (resetN),
    .din    ({hit, pickup, sw_inc, sw_dec}),
    .rise   (evt)
  );

  assign {hit_evt, pickup_evt, inc_sw_evt, dec_sw_evt} = evt;

  always_comb begin
    state_nxt = state;
    lives_nxt = lives;
    cnt_nxt   = cnt;
    lost_nxt  = 1'b0;
    died_nxt  = 1'b0;
    hit_acc   = hit_evt && (state == ALIVE);
    dec_evt   = hit_acc || dec_sw_evt;
    inc_evt   = pickup_evt || inc_sw_evt;
    if (restart) begin
      state_nxt = ALIVE;
      lives_nxt = LIVES_W'(INIT_LIVES);
      cnt_nxt   = '0;
    end else if (state != GAME_OVER) begin
      if (state == INVULN && startOfFrame) begin
        cnt_nxt = cnt - 1'b1;
        if (cnt_nxt == '0) state_nxt = ALIVE;
      end
      // A decrement in the same cycle as an increment wins outright.
      if (dec_evt) begin
        lives_nxt = sat_dec(lives);
        lost_nxt  = (lives != '0);
        if (lives_nxt == '0) begin
          state_nxt = GAME_OVER;
          cnt_nxt   = '0;
          died_nxt  = lost_nxt;
        end else if (hit_acc && INVULN_FRAMES > 0) begin
          state_nxt = INVULN;
          cnt_nxt   = CNT_W'(INVULN_FRAMES);
        end
      end else if (inc_evt) begin
        lives_nxt = sat_inc(lives);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= ALIVE;
      lives        <= LIVES_W'(INIT_LIVES);
      cnt          <= '0;
      invulnerable <= 1'b0;
      blink        <= 1'b0;
      life_lost    <= 1'b0;
      player_died  <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_nxt;
      lives        <= lives_nxt;
      cnt          <= cnt_nxt;
      invulnerable <= (state_nxt == INVULN);
      blink        <= (state_nxt == INVULN) && cnt_nxt[BLINK_BIT];
      life_lost    <= lost_nxt;
      player_died  <= died_nxt;
      game_over    <= (state_nxt == GAME_OVER);
    end
  end

endmodule

// File: tb/tb_lives_manager.sv
// Directed bench for lives_manager: single-cycle vector table plus window/reset sequences.
module tb_lives_manager;

  logic       clk = 1'b0;
  logic       resetN, startOfFrame, hit, pickup, sw_inc, sw_dec, restart;
  logic [3:0] lives;
  logic       invulnerable, blink, life_lost, player_died, game_over;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] in;   // {hit, pickup, sw_inc, sw_dec, restart}
    int         lv;
    logic [4:0] out;  // {invulnerable, blink, life_lost, player_died, game_over}
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  lives_manager #(
    .MAX_LIVES(5), .INIT_LIVES(3), .LIVES_W(4), .INVULN_FRAMES(120), .BLINK_BIT(3)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .hit          (hit),
    .pickup       (pickup),
    .sw_inc       (sw_inc),
    .sw_dec       (sw_dec),
    .restart      (restart),
    .lives        (lives),
    .invulnerable (invulnerable),
    .blink        (blink),
    .life_lost    (life_lost),
    .player_died  (player_died),
    .game_over    (game_over)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int lv, input logic [4:0] o);
    chk({tag, ".lives"}, int'(lives), lv);
    chk({tag, ".invulnerable"}, int'(invulnerable), int'(o[4]));
    chk({tag, ".blink"}, int'(blink), int'(o[3]));
    chk({tag, ".life_lost"}, int'(life_lost), int'(o[2]));
    chk({tag, ".player_died"}, int'(player_died), int'(o[1]));
    chk({tag, ".game_over"}, int'(game_over), int'(o[0]));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [4:0] in, input int lv, input logic [4:0] out);
    vec_t v;
    v.in = in; v.lv = lv; v.out = out;
    return v;
  endfunction

  initial begin
    int cnt_m;
    int frames;

    resetN = 1'b0; startOfFrame = 1'b0; hit = 1'b0; pickup = 1'b0;
    sw_inc = 1'b0; sw_dec = 1'b0; restart = 1'b0;
    repeat (2) cyc();
    chk_all("reset", 3, 5'b00000);
    resetN = 1'b1;

    // held sw_dec, saturating increments, restart suppression, hit+pickup, INVULN rules
    vecs.push_back(mk(5'b00000, 3, 5'b00000));
    vecs.push_back(mk(5'b00010, 2, 5'b00100));
    vecs.push_back(mk(5'b00010, 2, 5'b00000));
    vecs.push_back(mk(5'b00010, 2, 5'b00000));
    vecs.push_back(mk(5'b00000, 2, 5'b00000));
    vecs.push_back(mk(5'b00100, 3, 5'b00000));
    vecs.push_back(mk(5'b00000, 3, 5'b00000));
    vecs.push_back(mk(5'b00100, 4, 5'b00000));
    vecs.push_back(mk(5'b00000, 4, 5'b00000));
    vecs.push_back(mk(5'b00100, 5, 5'b00000));
    vecs.push_back(mk(5'b00000, 5, 5'b00000));
    vecs.push_back(mk(5'b00100, 5, 5'b00000));
    vecs.push_back(mk(5'b00000, 5, 5'b00000));
    vecs.push_back(mk(5'b01000, 5, 5'b00000));
    vecs.push_back(mk(5'b00000, 5, 5'b00000));
    vecs.push_back(mk(5'b00011, 3, 5'b00000));
    vecs.push_back(mk(5'b00010, 3, 5'b00000));
    vecs.push_back(mk(5'b00000, 3, 5'b00000));
    vecs.push_back(mk(5'b11000, 2, 5'b11100));
    vecs.push_back(mk(5'b00000, 2, 5'b11000));
    vecs.push_back(mk(5'b10000, 2, 5'b11000));
    vecs.push_back(mk(5'b01000, 3, 5'b11000));
    vecs.push_back(mk(5'b00010, 2, 5'b11100));
    vecs.push_back(mk(5'b00001, 3, 5'b00000));
    vecs.push_back(mk(5'b00000, 3, 5'b00000));
    // debug decrements into GAME_OVER, events ignored there, restart
    vecs.push_back(mk(5'b00010, 2, 5'b00100));
    vecs.push_back(mk(5'b00000, 2, 5'b00000));
    vecs.push_back(mk(5'b00010, 1, 5'b00100));
    vecs.push_back(mk(5'b00000, 1, 5'b00000));
    vecs.push_back(mk(5'b00010, 0, 5'b00111));
    vecs.push_back(mk(5'b00000, 0, 5'b00001));
    vecs.push_back(mk(5'b00100, 0, 5'b00001));
    vecs.push_back(mk(5'b01000, 0, 5'b00001));
    vecs.push_back(mk(5'b10000, 0, 5'b00001));
    vecs.push_back(mk(5'b00000, 0, 5'b00001));
    vecs.push_back(mk(5'b00001, 3, 5'b00000));
    vecs.push_back(mk(5'b00000, 3, 5'b00000));
    // last life taken by a gameplay hit goes straight to GAME_OVER
    vecs.push_back(mk(5'b00010, 2, 5'b00100));
    vecs.push_back(mk(5'b00000, 2, 5'b00000));
    vecs.push_back(mk(5'b00010, 1, 5'b00100));
    vecs.push_back(mk(5'b00000, 1, 5'b00000));
    vecs.push_back(mk(5'b10000, 0, 5'b00111));
    vecs.push_back(mk(5'b00001, 3, 5'b00000));
    vecs.push_back(mk(5'b00000, 3, 5'b00000));

    foreach (vecs[i]) begin
      {hit, pickup, sw_inc, sw_dec, restart} = vecs[i].in;
      cyc();
      chk_all($sformatf("vec%0d", i), vecs[i].lv, vecs[i].out);
    end
    {hit, pickup, sw_inc, sw_dec, restart} = 5'b00000;

    // full invulnerability window with a second hit five frames in
    hit = 1'b1;
    cyc();
    chk_all("win_hit", 2, 5'b11100);
    hit = 1'b0;
    cnt_m  = 120;
    frames = 0;
    for (int f = 0; f < 200 && cnt_m != 0; f++) begin
      hit = (f == 5);
      cyc();
      if (f == 5) begin
        chk("win_rehit.lives", int'(lives), 2);
        chk("win_rehit.life_lost", int'(life_lost), 0);
      end
      hit = 1'b0;
      repeat (2) cyc();
      startOfFrame = 1'b1;
      cyc();
      startOfFrame = 1'b0;
      cnt_m--;
      frames++;
      chk($sformatf("win_f%0d.invulnerable", frames), int'(invulnerable), int'(cnt_m != 0));
      chk($sformatf("win_f%0d.blink", frames), int'(blink),
          int'(cnt_m != 0 && ((cnt_m >> 3) & 1) == 1));
    end
    chk("win_frames", frames, 120);
    cyc();
    chk_all("win_end", 2, 5'b00000);

    // async reset in the middle of a fresh window
    hit = 1'b1;
    cyc();
    chk_all("rst_hit", 1, 5'b11100);
    hit = 1'b0;
    repeat (3) begin
      startOfFrame = 1'b1;
      cyc();
      startOfFrame = 1'b0;
      cyc();
    end
    chk_all("rst_mid", 1, 5'b10000);
    #3;
    resetN = 1'b0;
    hit = 1'b1;
    #1;
    chk_all("rst_async", 3, 5'b00000);
    cyc();
    chk_all("rst_held", 3, 5'b00000);
    hit = 1'b0;
    #2;
    resetN = 1'b1;
    cyc();
    chk_all("rst_release", 3, 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
